tetromino_bag_generator: RTL and testbench



---
 rtl/tetris_pkg.sv | 23 ++
 rtl/lfsr_galois.sv | 44 ++++
 rtl/tetromino_bag_generator.sv | 184 ++++++++++++++++++
 tb/tb_tetromino_bag_generator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared piece and bag-FSM types for the tetromino bag generator.
package tetris_pkg;

  localparam int NUM_PIECES = 7;
  localparam int IDX_W      = 3;

  typedef enum logic [2:0] {
    I = 3'd0,
    O,
    T,
    S,
    Z,
    J,
    L
  } piece_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    DRAW,
    PUSH
  } bag_state_t;

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with optional low-bit entropy mixing and reload.
// Never settles in the all-zero lock-up state: zero is replaced by SEED.
module lfsr_galois #(
  parameter int             W     = 16,
  parameter logic [W-1:0]   TAPS  = 16'hB400,
  parameter logic [W-1:0]   SEED  = 16'hACE1,
  parameter int             MIX_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             step,
  input  logic             mix_en,
  input  logic [MIX_W-1:0] mix_in,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  output logic [W-1:0]     state
);

  logic [W-1:0] state_d;

  always_comb begin
    state_d = state;
    if (step) begin
      state_d = {1'b0, state[W-1:1]} ^ (state[0] ? TAPS : '0);
    end
    if (mix_en) begin
      state_d[MIX_W-1:0] = state_d[MIX_W-1:0] ^ mix_in;
    end
    if (state_d == '0) begin
      state_d = SEED;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_val == '0) ? SEED : load_val;
    end else begin
      state <= state_d;
    end
  end

endmodule

// File: rtl/tetromino_bag_generator.sv
// 7-bag piece randomizer: LFSR-driven draws without replacement feeding a
// shift-register preview queue whose head is the current piece.
//
// state | meaning
// FILL  | idle; start a draw whenever the queue has a free slot
// DRAW  | test LFSR candidate against the bag; fall back after REJECT_LIMIT misses
// PUSH  | write the accepted piece to the queue tail; refill an emptied bag
module tetromino_bag_generator #(
  parameter int                NUM_PIECES    = tetris_pkg::NUM_PIECES,
  parameter int                IDX_W         = tetris_pkg::IDX_W,
  parameter int                PREVIEW_DEPTH = 3,
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
  parameter int                REJECT_LIMIT  = 4
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   seed_load,
  input  logic [LFSR_W-1:0]                      seed_in,
  input  logic                                   entropy_valid,
  input  logic [2:0]                             entropy_in,
  input  logic                                   pop,
  output logic                                   piece_valid,
  output logic [IDX_W-1:0]                       piece_idx,
  output logic [PREVIEW_DEPTH*IDX_W-1:0]         preview_idx,
  output logic [$clog2(PREVIEW_DEPTH+2)-1:0]     preview_count,
  output logic [IDX_W:0]                         bag_remaining
);

  import tetris_pkg::*;

  localparam int DEPTH = PREVIEW_DEPTH + 1;
  localparam int CNT_W = $clog2(PREVIEW_DEPTH + 2);
  localparam int RJ_W  = (REJECT_LIMIT < 1) ? 1 : $clog2(REJECT_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [RJ_W-1:0]  RJ_LIMIT = RJ_W'(REJECT_LIMIT);

  logic                     flush;
  logic [LFSR_W-1:0]        lfsr_state;
  logic                     unused_lfsr_bits;

  bag_state_t               state_q, state_d;
  logic [RJ_W-1:0]          rej_q, rej_d;
  logic [NUM_PIECES-1:0]    mask_q, mask_d;
  logic [IDX_W-1:0]         pick_q, pick_d;
  logic                     take;

  logic [(1<<IDX_W)-1:0]    mask_pad;
  logic [IDX_W-1:0]         cand;
  logic                     cand_ok;
  logic [IDX_W-1:0]         lowest;

  logic [IDX_W-1:0]         q_q [DEPTH];
  logic [IDX_W-1:0]         q_d [DEPTH];
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CNT_W-1:0]         wr_pos;
  logic                     do_pop, do_push;

  assign flush = Reset | seed_load;

  lfsr_galois #(
    .W     (LFSR_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED),
    .MIX_W (3)
  ) u_lfsr (
    .Clk      (Clk),
    .Reset    (Reset),
    .step     (1'b1),
    .mix_en   (entropy_valid),
    .mix_in   (entropy_in),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr_state)
  );

  assign cand             = lfsr_state[IDX_W-1:0];
  assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:IDX_W];

  // Zero padding makes out-of-range candidates read as "not in bag".
  always_comb begin
    mask_pad                 = '0;
    mask_pad[NUM_PIECES-1:0] = mask_q;
  end

  assign cand_ok = mask_pad[cand];

  always_comb begin
    lowest = '0;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (mask_q[i]) lowest = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    rej_d   = rej_q;
    mask_d  = mask_q;
    pick_d  = pick_q;
    take    = 1'b0;
    unique case (state_q)
      FILL: begin
        if (count_q < DEPTH_C) state_d = DRAW;
      end
      DRAW: begin
        if (cand_ok) begin
          pick_d = cand;
          take   = 1'b1;
        end else if (rej_q == RJ_LIMIT) begin
          pick_d = lowest;
          take   = 1'b1;
        end else begin
          rej_d = rej_q + 1'b1;
        end
        if (take) begin
          for (int i = 0; i < NUM_PIECES; i++) begin
            if (pick_d == IDX_W'(i)) mask_d[i] = 1'b0;
          end
          rej_d   = '0;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (mask_q == '0) mask_d = '1;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Queue entries above the occupancy are kept at zero, so unused preview
  // slots read 0 without extra masking.
  always_comb begin
    do_pop  = pop & (count_q != '0);
    do_push = (state_q == PUSH);
    wr_pos  = count_q - CNT_W'(do_pop);
    for (int i = 0; i < DEPTH; i++) q_d[i] = q_q[i];
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_q[i+1];
      q_d[DEPTH-1] = '0;
    end
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_pos == CNT_W'(i)) q_d[i] = pick_q;
      end
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge Clk) begin
    if (flush) begin
      state_q <= FILL;
      rej_q   <= '0;
      mask_q  <= '1;
      pick_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rej_q   <= rej_d;
      mask_q  <= mask_d;
      pick_q  <= pick_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
    end
  end

  assign piece_valid   = (count_q != '0);
  assign piece_idx     = q_q[0];
  assign preview_count = piece_valid ? (count_q - 1'b1) : '0;

  for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
    assign preview_idx[g*IDX_W +: IDX_W] = q_q[g+1];
  end

  always_comb begin
    bag_remaining = '0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      bag_remaining = bag_remaining + (IDX_W+1)'(mask_q[i]);
    end
  end

endmodule

// File: tb/tb_tetromino_bag_generator.sv
// Directed bench for tetromino_bag_generator with a queue-based reference
// model compared against the outputs on every falling clock edge.
module tb_tetromino_bag_generator;

  localparam int          NP    = 7;
  localparam int          PD    = 3;
  localparam int          DEPTH = PD + 1;
  localparam int          LIM   = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] TAPS  = 16'hB400;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0;
  logic        entropy_valid = 1'b0;
  logic [2:0]  entropy_in = 3'd0;
  logic        pop = 1'b0;
  logic        piece_valid;
  logic [2:0]  piece_idx;
  logic [8:0]  preview_idx;
  logic [2:0]  preview_count;
  logic [3:0]  bag_remaining;

  tetromino_bag_generator dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .seed_load     (seed_load),
    .seed_in       (seed_in),
    .entropy_valid (entropy_valid),
    .entropy_in    (entropy_in),
    .pop           (pop),
    .piece_valid   (piece_valid),
    .piece_idx     (piece_idx),
    .preview_idx   (preview_idx),
    .preview_count (preview_count),
    .bag_remaining (bag_remaining)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr;
  bit          m_bag [NP];
  int          m_q [$];
  int          m_rej, m_phase, m_pick, m_sz, m_cand, m_take;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s, input bit mix, input logic [2:0] v);
    logic [15:0] n = s >> 1;
    if (s[0]) n = n ^ TAPS;
    if (mix) n[2:0] = n[2:0] ^ v;
    if (n == 16'h0) n = SEED;
    return n;
  endfunction

  function automatic int bag_left();
    int n = 0;
    foreach (m_bag[i]) n += int'(m_bag[i]);
    return n;
  endfunction

  always @(posedge Clk) begin
    if (Reset || seed_load) begin
      m_lfsr = Reset ? SEED : ((seed_in != 16'h0) ? seed_in : SEED);
      foreach (m_bag[i]) m_bag[i] = 1'b1;
      m_q.delete();
      m_rej = 0; m_phase = 0; m_pick = 0;
    end else begin
      m_sz = m_q.size();
      if (pop && m_sz > 0) void'(m_q.pop_front());
      if (m_phase == 2) m_q.push_back(m_pick);
      case (m_phase)
        0: if (m_sz < DEPTH) m_phase = 1;
        1: begin
          m_cand = int'(m_lfsr[2:0]);
          m_take = -1;
          if (m_cand < NP && m_bag[m_cand]) m_take = m_cand;
          else if (m_rej == LIM) begin
            for (int i = NP - 1; i >= 0; i--) if (m_bag[i]) m_take = i;
          end else m_rej++;
          if (m_take >= 0) begin
            m_bag[m_take] = 1'b0;
            m_pick = m_take; m_rej = 0; m_phase = 2;
          end
        end
        default: begin
          if (bag_left() == 0) foreach (m_bag[i]) m_bag[i] = 1'b1;
          m_phase = 0;
        end
      endcase
      m_lfsr = lfsr_next(m_lfsr, entropy_valid, entropy_in);
    end
  end

  logic [8:0] c_prev;
  always @(negedge Clk) begin
    if (chk_en) begin
      c_prev = '0;
      for (int i = 1; i <= PD; i++) if (i < m_q.size()) c_prev[(i-1)*3 +: 3] = 3'(m_q[i]);
      chk("valid", int'(piece_valid), int'(m_q.size() > 0));
      chk("head", int'(piece_idx), (m_q.size() > 0) ? m_q[0] : 0);
      chk("preview", int'(preview_idx), int'(c_prev));
      chk("pcount", int'(preview_count), (m_q.size() > 0) ? m_q.size() - 1 : 0);
      chk("bag_rem", int'(bag_remaining), bag_left());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1; tick(1); Reset = 1'b0;
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed_in = s; seed_load = 1'b1; tick(1); seed_load = 1'b0;
  endtask

  int seq_buf [21];
  int seq_a [21], seq_b [21], seq_c [21], seq_d [21];

  task automatic run21();
    tick(8);
    for (int k = 0; k < 21; k++) begin
      chk("seq_valid", int'(piece_valid), 1);
      seq_buf[k] = int'(piece_idx);
      pop = 1'b1; tick(1); pop = 1'b0; tick(7);
    end
  endtask

  int  v [4];
  bit [7:0] seen;
  int  nd, cyc, old_pc, exp_head, exp_tail;
  int  popped [70];
  bit  found;

  initial begin
    @(negedge Clk);
    chk_en = 1'b1;
    chk("rst_valid", int'(piece_valid), 0);
    chk("rst_bag", int'(bag_remaining), 7);
    chk("rst_prev", int'(preview_idx), 0);
    chk("rst_pcount", int'(preview_count), 0);
    Reset = 1'b0;

    // Seed 0xACE1 with no entropy gives pieces 0, 6, 1 at edges 3, 6, 9.
    tick(2); chk("first_not_yet", int'(piece_valid), 0);
    tick(1); chk("first_valid", int'(piece_valid), 1);
    chk("first_idx", int'(piece_idx), 0);
    tick(6);
    chk("pin_slot0", int'(preview_idx[2:0]), 6);
    chk("pin_slot1", int'(preview_idx[5:3]), 1);
    chk("pin_pcount", int'(preview_count), 2);
    chk("pin_bag", int'(bag_remaining), 4);

    tick(20);
    chk("fill_pcount", int'(preview_count), 3);
    chk("fill_bag", int'(bag_remaining), 3);
    v[0] = int'(piece_idx); v[1] = int'(preview_idx[2:0]);
    v[2] = int'(preview_idx[5:3]); v[3] = int'(preview_idx[8:6]);
    seen = '0; nd = 0;
    for (int i = 0; i < 4; i++) if (v[i] < 7 && !seen[v[i]]) begin seen[v[i]] = 1'b1; nd++; end
    chk("fill_distinct", nd, 4);

    for (int k = 0; k < 70; k++) begin
      chk("spaced_valid", int'(piece_valid), 1);
      popped[k] = int'(piece_idx);
      pop = 1'b1; entropy_valid = (k % 3 == 0); entropy_in = 3'(k * 5);
      tick(1);
      pop = 1'b0; entropy_valid = 1'b0;
      tick(7);
    end
    for (int b = 0; b < 10; b++) begin
      seen = '0;
      for (int j = 0; j < 7; j++) if (popped[b*7+j] < 7) seen[popped[b*7+j]] = 1'b1;
      chk("bag_perm", int'(seen[6:0]), 8'h7F);
    end

    do_reset();  run21(); seq_a = seq_buf;
    do_seed(16'h0);    run21(); seq_b = seq_buf;
    do_seed(16'h1234); run21(); seq_c = seq_buf;
    do_seed(16'h1234); run21(); seq_d = seq_buf;
    for (int k = 0; k < 21; k++) begin
      chk("seed0_vs_reset", seq_b[k], seq_a[k]);
      chk("seed1234_repeat", seq_d[k], seq_c[k]);
    end

    do_reset(); tick(30);
    pop = 1'b1; tick(1); pop = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (m_phase == 2) found = 1'b1; else tick(1);
    end
    chk("coin_found", int'(found), 1);
    if (found) begin
      exp_head = m_q[1]; exp_tail = m_pick; old_pc = int'(preview_count);
      chk("coin_pre_pcount", old_pc, 2);
      pop = 1'b1; tick(1); pop = 1'b0;
      chk("coin_head", int'(piece_idx), exp_head);
      chk("coin_pcount", int'(preview_count), 2);
      chk("coin_tail", int'(preview_idx[5:3]), exp_tail);
    end

    Reset = 1'b1; pop = 1'b1; tick(1); Reset = 1'b0;
    cyc = 0;
    while (!piece_valid && cyc < 10) begin tick(1); cyc++; end
    pop = 1'b0;
    chk("hold_latency", cyc, 3);
    chk("hold_first_idx", int'(piece_idx), 0);
    chk("hold_pcount", int'(preview_count), 0);
    tick(1);

    do_reset();
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (m_phase == 1 && bag_left() == 2) found = 1'b1;
      else begin pop = (c % 8 == 0); tick(1); pop = 1'b0; end
    end
    chk("middraw_found", int'(found), 1);
    chk("middraw_bag", int'(bag_remaining), 2);
    Reset = 1'b1; tick(1);
    chk("rst_mid_bag", int'(bag_remaining), 7);
    chk("rst_mid_valid", int'(piece_valid), 0);
    chk("rst_mid_prev", int'(preview_idx), 0);
    Reset = 1'b0;
    cyc = 0;
    while (!piece_valid && cyc < 10) begin tick(1); cyc++; end
    chk("refill_latency_ok", int'(cyc <= LIM + 3), 1);
    tick(4);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
